rom_port_arbiter: RTL
=====================

// Module: rom_port_arbiter
// PURPOSE
//  Shares the single 8K x 16 program ROM (Gowin_pROM, sync read) between two requesters:
//  port 0 = CPU instruction fetch, port 1 = CPU data/constant load.
//  Round-robin grant, pipelined tag tracking, per-port read-data return with hold.
//  Sits between the brus16 core and Gowin_pROM; it is the only driver of the ROM control pins.
// PARAMETERS
//  ADDR_W     13     ROM word-address width (8192 words)
//  DATA_W     16     ROM word width
//  ROM_WORDS  8192   populated depth; addresses >= ROM_WORDS are out of range
//  RD_LAT     1      ROM read latency in clocks (1 = bypass mode, 2 = pipeline mode); legal values 1..2
// PORTS
//  clk             in   1       system clock
//  reset           in   1       async, active-high reset
//  p0_req          in   1       port 0 read request; hold with p0_addr stable until p0_gnt
//  p0_addr         in   ADDR_W  port 0 word address
//  p0_gnt          out  1       port 0 request accepted this cycle
//  p0_rvalid       out  1       1-cycle pulse: p0_rdata updated
//  p0_rdata        out  DATA_W  port 0 read data, held until next p0_rvalid
//  p1_req/p1_addr/p1_gnt/p1_rvalid/p1_rdata   same as port 0, for port 1
//  oor_err         out  1       1-cycle pulse: a granted address was out of range
//  rom_ce          out  1       to Gowin_pROM.ce
//  rom_oce         out  1       to Gowin_pROM.oce, constant 1
//  rom_reset       out  1       to Gowin_pROM.reset, equals reset
//  rom_ad          out  ADDR_W  to Gowin_pROM.ad
//  rom_dout        in   DATA_W  from Gowin_pROM.dout
// BEHAVIOUR
//  Reset values: p*_gnt=0, p*_rvalid=0, p*_rdata=0, oor_err=0, rom_ce=0, priority pointer=port 0, tag pipe empty.
//  Grant is combinational from req and pointer: one grant per cycle max, gnt only when req=1.
//  Arbitration: only one req -> grant it. Both req -> grant the port the pointer names; pointer flips to the
//  other port after every grant. One port repeating its req alone is granted every cycle (no bubble).
//  Issue: in the grant cycle rom_ce=1 and rom_ad=granted addr. The ROM samples the address at that edge.
//  No grant -> rom_ce=0, rom_ad holds its last value.
//  Tag pipe: RD_LAT-deep shift register of {valid, port, oor}, loaded at the grant edge.
//  Return: when the tag leaves the pipe (RD_LAT cycles after the grant edge), the named port gets
//  rvalid=1, and rdata <- rom_dout, registered.
//  Fixed latency: grant cycle N -> p*_rvalid asserted in cycle N+RD_LAT+1.
//  Out of range: the access is still issued. The return delivers rdata=0, and oor_err pulses in the same
//  cycle as that rvalid.
//  Throughput: 1 read per clock sustained, ports interleaved when both request.
//  rdata of a port is never changed except together with its own rvalid.
//  Reset mid-operation: in-flight tags are discarded, no rvalid follows, and the pointer returns to port 0.
//  Requesters must re-issue after reset.
//  Request withdrawn before gnt: legal, no access issued.
// STRUCTURE
//  Package brus16_rom_pkg: ROM_ADDR_W, ROM_DATA_W, ROM_WORDS, port-index enum (PORT_FETCH=0, PORT_DATA=1),
//  and the tag struct type.
//  Sub-module rr_arbiter2: 2-way round-robin (req[1:0] -> gnt[1:0], pointer register, async reset).
//  Top: tag pipe, return registers, ROM pin drive.
// TESTING  (model the ROM as a behavioural RD_LAT-cycle sync memory, mem[a]=a^16'hA5A5)
//  1. p0 only, addr 0x0000..0x0007 back-to-back -> p0_gnt every cycle; p0_rdata = 0xA5A5, 0xA5A4, ... each
//     at grant+RD_LAT+1; p1_rvalid stays 0.
//  2. p0 and p1 req together for 6 cycles (p0 0x10, p1 0x20) -> grants alternate p0, p1, p0, ...;
//     each port's rdata is correct and held between its own rvalids.
//  3. After reset, both request in the first cycle -> p0 granted first; next cycle p1 is granted.
//  4. Read at addr 0x1FFF with ROM_WORDS=4096 -> rvalid with rdata=0, oor_err pulses the same cycle;
//     the following in-range read is unaffected.
//  5. Assert reset while 2 reads are in flight -> no rvalid after reset; all outputs are 0;
//     rdata holds 0 until the first new read.
//  6. RD_LAT=2 build, repeat scenarios 1 and 2 -> latency grant+3, ordering and data unchanged.

Source files
------------

// File: rtl/brus16_rom_pkg.sv
// Shared types and sizes for the brus16 program-ROM access path.
// Port numbering matches the arbiter's req/gnt bit positions.
package brus16_rom_pkg;

    localparam int ROM_ADDR_W = 13;
    localparam int ROM_DATA_W = 16;
    localparam int ROM_WORDS  = 8192;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DATA  = 1'b1
    } port_e;

    typedef struct packed {
        logic  valid;
        port_e port;
        logic  oor;
    } rom_tag_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to the
// pointed-at port, and the pointer then moves to the port that was not granted.
module rr_arbiter2
    import brus16_rom_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    port_e ptr;

    // Grants are suppressed during reset so nothing reaches the ROM pins.
    always_comb begin
        gnt = 2'b00;
        if (!reset) begin
            if (req == 2'b11) begin
                gnt = (ptr == PORT_DATA) ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= PORT_FETCH;
        end else if (gnt[0]) begin
            ptr <= PORT_DATA;
        end else if (gnt[1]) begin
            ptr <= PORT_FETCH;
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the synchronous program ROM between instruction fetch (port 0) and
// data load (port 1): one issue per clock, fixed-latency tagged return.
module rom_port_arbiter
    import brus16_rom_pkg::*;
#(
    parameter int ADDR_W    = ROM_ADDR_W,
    parameter int DATA_W    = ROM_DATA_W,
    parameter int ROM_WORDS = brus16_rom_pkg::ROM_WORDS,
    parameter int RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic [ADDR_W-1:0] p0_addr,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic [ADDR_W-1:0] p1_addr,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              oor_err,
    output logic              rom_ce,
    output logic              rom_oce,
    output logic              rom_reset,
    output logic [ADDR_W-1:0] rom_ad,
    input  logic [DATA_W-1:0] rom_dout
);

    localparam logic [ADDR_W:0] ROM_LIMIT = (ADDR_W + 1)'(ROM_WORDS);

    logic [1:0]        gnt;
    logic              any_gnt;
    port_e             gnt_port;
    logic [ADDR_W-1:0] gnt_addr;
    logic              gnt_oor;
    logic [ADDR_W-1:0] last_ad;
    rom_tag_t          tag_pipe [RD_LAT];
    rom_tag_t          ret_tag;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({p1_req, p0_req}),
        .gnt   (gnt)
    );

    assign p0_gnt   = gnt[0];
    assign p1_gnt   = gnt[1];
    assign any_gnt  = |gnt;
    assign gnt_port = gnt[1] ? PORT_DATA : PORT_FETCH;
    assign gnt_addr = gnt[1] ? p1_addr : p0_addr;
    assign gnt_oor  = {1'b0, gnt_addr} >= ROM_LIMIT;

    // The ROM sees the granted address in the grant cycle; otherwise the bus parks.
    assign rom_ce    = any_gnt;
    assign rom_ad    = any_gnt ? gnt_addr : last_ad;
    assign rom_oce   = 1'b1;
    assign rom_reset = reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_ad <= '0;
        end else if (any_gnt) begin
            last_ad <= gnt_addr;
        end
    end

    // Tags travel alongside the ROM pipeline so each word finds its owner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= '{valid: any_gnt, port: gnt_port, oor: gnt_oor};
            for (int i = 1; i < RD_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign ret_tag = tag_pipe[RD_LAT-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
            oor_err   <= 1'b0;
        end else begin
            p0_rvalid <= ret_tag.valid && (ret_tag.port == PORT_FETCH);
            p1_rvalid <= ret_tag.valid && (ret_tag.port == PORT_DATA);
            oor_err   <= ret_tag.valid && ret_tag.oor;
            if (ret_tag.valid && (ret_tag.port == PORT_FETCH)) begin
                p0_rdata <= ret_tag.oor ? '0 : rom_dout;
            end
            if (ret_tag.valid && (ret_tag.port == PORT_DATA)) begin
                p1_rdata <= ret_tag.oor ? '0 : rom_dout;
            end
        end
    end

endmodule
